sordm5_keyboard: RTL and testbench

Converts MiSTer PS/2 key events (`ps2_key` from hps_io) into the Sord M5 keyboard matrix consumed by the `sordM5` core's I/O decoder.
- Holds an 8×8 key-state matrix, updated from the PS/2 event stream.
- Returns the row selected by the CPU I/O read (ports 30h–37h).
- Drives the M5 RESET key line, which the core routes to the Z80 NMI.
- Sits between hps_io and the `sordM5` console core, in the `clk_sys` domain.

---
 rtl/sordm5_kbd_pkg.sv | 34 +++
 rtl/sordm5_kbd_map.sv | 97 +++++++++
 rtl/sordm5_keyboard.sv | 126 ++++++++++++
 tb/tb_sordm5_keyboard.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sordm5_kbd_pkg.sv
// Shared types for the Sord M5 keyboard bridge: matrix coordinates, lookup result, row indices.
package sordm5_kbd_pkg;

    typedef logic [2:0] kbd_row_t;
    typedef logic [2:0] kbd_col_t;

    typedef struct packed {
        logic     hit;
        kbd_row_t row;
        kbd_col_t col;
        logic     is_reset;
    } map_entry_t;

    localparam kbd_row_t ROW_MOD = 3'd0;
    localparam kbd_row_t ROW_NUM = 3'd1;
    localparam kbd_row_t ROW_QWE = 3'd2;
    localparam kbd_row_t ROW_ASD = 3'd3;
    localparam kbd_row_t ROW_ZXC = 3'd4;
    localparam kbd_row_t ROW_SYM = 3'd5;
    localparam kbd_row_t ROW_OPL = 3'd6;
    localparam kbd_row_t ROW_JOY = 3'd7;

    localparam logic [7:0] CODE_F12 = 8'h07;

    function automatic map_entry_t key_at(kbd_row_t row, kbd_col_t col);
        map_entry_t e;
        e.hit      = 1'b1;
        e.row      = row;
        e.col      = col;
        e.is_reset = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/sordm5_kbd_map.sv
// Registered PS/2 set-2 scancode to M5 matrix position lookup (one cycle latency).
module sordm5_kbd_map
    import sordm5_kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ext,
    input  logic [7:0] code,
    output map_entry_t entry
);

    map_entry_t entry_d;

    always_comb begin
        entry_d = '0;
        if (ext) begin
            case (code)
                8'h14:   entry_d = key_at(ROW_MOD, 3'd0);   // right ctrl
                8'h11:   entry_d = key_at(ROW_MOD, 3'd1);   // right alt
                8'h5A:   entry_d = key_at(ROW_MOD, 3'd7);   // keypad enter
                default: entry_d = '0;
            endcase
        end else begin
            case (code)
                8'h14:   entry_d = key_at(ROW_MOD, 3'd0);
                8'h11:   entry_d = key_at(ROW_MOD, 3'd1);
                8'h12:   entry_d = key_at(ROW_MOD, 3'd2);
                8'h59:   entry_d = key_at(ROW_MOD, 3'd3);
                8'h29:   entry_d = key_at(ROW_MOD, 3'd6);
                8'h5A:   entry_d = key_at(ROW_MOD, 3'd7);
                8'h16:   entry_d = key_at(ROW_NUM, 3'd0);
                8'h1E:   entry_d = key_at(ROW_NUM, 3'd1);
                8'h26:   entry_d = key_at(ROW_NUM, 3'd2);
                8'h25:   entry_d = key_at(ROW_NUM, 3'd3);
                8'h2E:   entry_d = key_at(ROW_NUM, 3'd4);
                8'h36:   entry_d = key_at(ROW_NUM, 3'd5);
                8'h3D:   entry_d = key_at(ROW_NUM, 3'd6);
                8'h3E:   entry_d = key_at(ROW_NUM, 3'd7);
                8'h15:   entry_d = key_at(ROW_QWE, 3'd0);
                8'h1D:   entry_d = key_at(ROW_QWE, 3'd1);
                8'h24:   entry_d = key_at(ROW_QWE, 3'd2);
                8'h2D:   entry_d = key_at(ROW_QWE, 3'd3);
                8'h2C:   entry_d = key_at(ROW_QWE, 3'd4);
                8'h35:   entry_d = key_at(ROW_QWE, 3'd5);
                8'h3C:   entry_d = key_at(ROW_QWE, 3'd6);
                8'h43:   entry_d = key_at(ROW_QWE, 3'd7);
                8'h1C:   entry_d = key_at(ROW_ASD, 3'd0);
                8'h1B:   entry_d = key_at(ROW_ASD, 3'd1);
                8'h23:   entry_d = key_at(ROW_ASD, 3'd2);
                8'h2B:   entry_d = key_at(ROW_ASD, 3'd3);
                8'h34:   entry_d = key_at(ROW_ASD, 3'd4);
                8'h33:   entry_d = key_at(ROW_ASD, 3'd5);
                8'h3B:   entry_d = key_at(ROW_ASD, 3'd6);
                8'h42:   entry_d = key_at(ROW_ASD, 3'd7);
                8'h1A:   entry_d = key_at(ROW_ZXC, 3'd0);
                8'h22:   entry_d = key_at(ROW_ZXC, 3'd1);
                8'h21:   entry_d = key_at(ROW_ZXC, 3'd2);
                8'h2A:   entry_d = key_at(ROW_ZXC, 3'd3);
                8'h32:   entry_d = key_at(ROW_ZXC, 3'd4);
                8'h31:   entry_d = key_at(ROW_ZXC, 3'd5);
                8'h3A:   entry_d = key_at(ROW_ZXC, 3'd6);
                8'h41:   entry_d = key_at(ROW_ZXC, 3'd7);
                // '=' stands in for '^'; JP ro / yen keys carry '_' and '\'
                8'h46:   entry_d = key_at(ROW_SYM, 3'd0);
                8'h45:   entry_d = key_at(ROW_SYM, 3'd1);
                8'h4E:   entry_d = key_at(ROW_SYM, 3'd2);
                8'h55:   entry_d = key_at(ROW_SYM, 3'd3);
                8'h49:   entry_d = key_at(ROW_SYM, 3'd4);
                8'h4A:   entry_d = key_at(ROW_SYM, 3'd5);
                8'h51:   entry_d = key_at(ROW_SYM, 3'd6);
                8'h6A:   entry_d = key_at(ROW_SYM, 3'd7);
                8'h44:   entry_d = key_at(ROW_OPL, 3'd0);
                8'h4D:   entry_d = key_at(ROW_OPL, 3'd1);
                8'h54:   entry_d = key_at(ROW_OPL, 3'd2);
                8'h5B:   entry_d = key_at(ROW_OPL, 3'd3);
                8'h4B:   entry_d = key_at(ROW_OPL, 3'd4);
                8'h4C:   entry_d = key_at(ROW_OPL, 3'd5);
                8'h52:   entry_d = key_at(ROW_OPL, 3'd6);
                8'h5D:   entry_d = key_at(ROW_OPL, 3'd7);
                CODE_F12: begin
                    entry_d          = '0;
                    entry_d.is_reset = 1'b1;
                end
                default: entry_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else begin
            entry <= entry_d;
        end
    end

endmodule

// File: rtl/sordm5_keyboard.sv
// MiSTer ps2_key event stream to Sord M5 8x8 keyboard matrix and RESET key.
// Optional joystick row 7 enabled by defining SORDM5_KBD_JOY_EN.
module sordm5_keyboard
    import sordm5_kbd_pkg::*;
#(
    parameter int MAP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [10:0] ps2_key_i,
    input  logic [2:0]  row_sel_i,
    output logic [7:0]  row_data_o,
    output logic        reset_key_o,
    output logic        any_key_o
`ifdef SORDM5_KBD_JOY_EN
    ,
    input  logic [4:0]  joy0_i,
    input  logic [4:0]  joy1_i
`endif
);

    logic                   toggle_q;
    logic                   primed_q;
    logic                   valid1;
    logic                   pressed1;
    logic                   ext1;
    logic [7:0]             code1;
    logic [MAP_LATENCY-1:0] valid2;
    logic                   pressed2;
    map_entry_t             entry;
    logic [7:0]             matrix [8];
    logic                   reset_key_q;
    logic                   any_key_q;
    logic [7:0]             row7;
    logic                   matrix_any;

    // First cycle after reset only captures the toggle level, so a static
    // ps2_key_i[10] never looks like a fresh event.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            toggle_q <= 1'b0;
            primed_q <= 1'b0;
            valid1   <= 1'b0;
            pressed1 <= 1'b0;
            ext1     <= 1'b0;
            code1    <= '0;
        end else begin
            primed_q <= 1'b1;
            toggle_q <= ps2_key_i[10];
            valid1   <= primed_q && (ps2_key_i[10] != toggle_q);
            pressed1 <= ps2_key_i[9];
            ext1     <= ps2_key_i[8];
            code1    <= ps2_key_i[7:0];
        end
    end

    sordm5_kbd_map u_map (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .ext   (ext1),
        .code  (code1),
        .entry (entry)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid2   <= '0;
            pressed2 <= 1'b0;
        end else begin
            valid2   <= {MAP_LATENCY{valid1}};
            pressed2 <= pressed1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < 8; r++) begin
                matrix[r] <= '0;
            end
            reset_key_q <= 1'b0;
        end else if (valid2[MAP_LATENCY-1]) begin
            if (entry.hit) begin
                matrix[entry.row][entry.col] <= pressed2;
            end
            if (entry.is_reset) begin
                reset_key_q <= pressed2;
            end
        end
    end

`ifdef SORDM5_KBD_JOY_EN
    logic [7:0] joy_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            joy_q <= '0;
        end else begin
            joy_q <= {joy1_i[4], joy0_i[4], joy1_i[1:0], joy0_i[3:0]};
        end
    end

    assign row7 = matrix[ROW_JOY] | joy_q;
`else
    assign row7 = 8'h00;
`endif

    always_comb begin
        matrix_any = |row7;
        for (int r = 0; r < 7; r++) begin
            matrix_any = matrix_any | (|matrix[r]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            any_key_q <= 1'b0;
        end else begin
            any_key_q <= matrix_any;
        end
    end

    assign row_data_o  = (row_sel_i == ROW_JOY) ? row7 : matrix[row_sel_i];
    assign reset_key_o = reset_key_q;
    assign any_key_o   = any_key_q;

endmodule

// File: tb/tb_sordm5_keyboard.sv
// Directed bench for sordm5_keyboard: event latency, matrix updates, F12, reset mid-pipeline.
module tb_sordm5_keyboard;

    logic        clk;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [2:0]  row_sel;
    logic [7:0]  row_data;
    logic        reset_key;
    logic        any_key;
`ifdef SORDM5_KBD_JOY_EN
    logic [4:0]  joy0;
    logic [4:0]  joy1;
`endif

    int checks;
    int errors;

    sordm5_keyboard #(.MAP_LATENCY(1)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .ps2_key_i   (ps2_key),
        .row_sel_i   (row_sel),
        .row_data_o  (row_data),
        .reset_key_o (reset_key),
        .any_key_o   (any_key)
`ifdef SORDM5_KBD_JOY_EN
        ,
        .joy0_i      (joy0),
        .joy1_i      (joy1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One event per call, applied just after a falling edge.
    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        @(negedge clk);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [2:0] r, input logic [7:0] exp);
        row_sel = r;
        #1;
        chk($sformatf("%s_row%0d", tag, r), row_data, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        ps2_key = '0;
        row_sel = '0;
`ifdef SORDM5_KBD_JOY_EN
        joy0 = '0;
        joy1 = '0;
`endif
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(3);

        // Reset state
        for (int r = 0; r < 8; r++) chk_row("reset", 3'(r), 8'h00);
        chk("reset_any", {7'd0, any_key}, 8'h00);
        chk("reset_rkey", {7'd0, reset_key}, 8'h00);

        // A press: matrix at N+2, any_key at N+3
        send(1'b1, 1'b0, 8'h1C);
        wait_neg(2);
        chk_row("a_early", 3'd3, 8'h00);
        wait_neg(1);
        chk_row("a_press", 3'd3, 8'h01);
        chk("a_any_early", {7'd0, any_key}, 8'h00);
        wait_neg(1);
        chk("a_any", {7'd0, any_key}, 8'h01);

        // Repeat press (idempotent) followed immediately by release
        send(1'b1, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1C);
        wait_neg(2);
        chk_row("a_repress", 3'd3, 8'h01);
        wait_neg(1);
        chk_row("a_release", 3'd3, 8'h00);
        chk("a_rel_any_lag", {7'd0, any_key}, 8'h01);
        wait_neg(1);
        chk("a_rel_any", {7'd0, any_key}, 8'h00);

        // LShift, Q, 1 back-to-back
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h15);
        send(1'b1, 1'b0, 8'h16);
        wait_neg(3);
        chk_row("multi", 3'd0, 8'h04);
        chk_row("multi", 3'd2, 8'h01);
        chk_row("multi", 3'd1, 8'h01);
        send(1'b0, 1'b0, 8'h12);
        send(1'b0, 1'b0, 8'h15);
        send(1'b0, 1'b0, 8'h16);
        wait_neg(3);
        chk_row("multi_rel", 3'd0, 8'h00);
        chk_row("multi_rel", 3'd2, 8'h00);
        chk_row("multi_rel", 3'd1, 8'h00);

        // Extended right ctrl, then unmapped code, then release of a key not down
        send(1'b1, 1'b1, 8'h14);
        wait_neg(3);
        chk_row("rctrl", 3'd0, 8'h01);
        send(1'b1, 1'b0, 8'h0E);
        wait_neg(3);
        for (int r = 0; r < 8; r++) chk_row("unmapped", 3'(r), (r == 0) ? 8'h01 : 8'h00);
        send(1'b0, 1'b0, 8'h42);
        wait_neg(3);
        chk_row("rel_up", 3'd3, 8'h00);
        chk_row("rel_up", 3'd0, 8'h01);

        // F12 drives the RESET key without touching the matrix
        send(1'b1, 1'b0, 8'h07);
        wait_neg(2);
        chk("f12_early", {7'd0, reset_key}, 8'h00);
        wait_neg(1);
        chk("f12_press", {7'd0, reset_key}, 8'h01);
        for (int r = 0; r < 8; r++) chk_row("f12_mat", 3'(r), (r == 0) ? 8'h01 : 8'h00);
        send(1'b0, 1'b0, 8'h07);
        wait_neg(3);
        chk("f12_release", {7'd0, reset_key}, 8'h00);
        send(1'b1, 1'b0, 8'h07);
        wait_neg(3);
        chk("f12_again", {7'd0, reset_key}, 8'h01);
        chk("held_any", {7'd0, any_key}, 8'h01);

        // Reset with an A press in flight
        send(1'b1, 1'b0, 8'h1C);
        wait_neg(1);
        reset_n = 1'b0;
        #1;
        chk("rst_any", {7'd0, any_key}, 8'h00);
        chk("rst_rkey", {7'd0, reset_key}, 8'h00);
        for (int r = 0; r < 8; r++) chk_row("rst_now", 3'(r), 8'h00);
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(5);
        for (int r = 0; r < 8; r++) chk_row("post_rst", 3'(r), 8'h00);
        chk("post_rst_any", {7'd0, any_key}, 8'h00);
        chk("post_rst_rkey", {7'd0, reset_key}, 8'h00);

`ifdef SORDM5_KBD_JOY_EN
        joy0 = 5'b10001;
        wait_neg(2);
        chk_row("joy", 3'd7, 8'h41);
        chk("joy_any", {7'd0, any_key}, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
